// File: rtl/instr_word_packer.sv
// Packs decoded RV64 instruction fields into 32-bit words and buffers them,
// tagged with sequential byte addresses, in a small in-order FIFO.
module instr_word_packer #(
  parameter logic [63:0] BASE_ADDR  = 64'd0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [6:0]  in_funct7,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_addr,
  output logic        range_err,
  output logic [15:0] count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem_instr [FIFO_DEPTH];
  logic [63:0]   mem_addr  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ;
  logic [63:0]   next_addr;

  logic [31:0]   word_c;
  logic          is_r_c, imm_ok_c, fifo_full_c, accept_c, push_c, pop_c;
  logic [AW-1:0] next_rd_c;
  logic [CW-1:0] next_occ_c;

  // Field packing; immediate slices overwrite the register fields they overlap.
  always_comb begin
    word_c = {7'd0, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    is_r_c = (in_opcode[6:4] == 3'b011);
    if (is_r_c) begin
      word_c[31:25] = in_funct7;
    end else if (in_opcode[6:5] == 2'b00) begin
      word_c[31:20] = in_imm[11:0];
    end else if (in_opcode[6:5] == 2'b01) begin
      word_c[31:25] = in_imm[11:5];
      word_c[11:7]  = in_imm[4:0];
    end else begin
      word_c[31]    = in_imm[11];
      word_c[30:25] = in_imm[9:4];
      word_c[11:8]  = in_imm[3:0];
      word_c[7]     = in_imm[10];
    end
  end

  assign imm_ok_c    = (&in_imm[63:11]) | ~(|in_imm[63:11]);
  assign fifo_full_c = (occ == CW'(FIFO_DEPTH));
  assign in_ready    = reset & ~fifo_full_c & ~start;
  assign accept_c    = in_valid & in_ready;
  assign push_c      = accept_c & (is_r_c | imm_ok_c);
  assign pop_c       = out_valid & out_ready;
  assign next_rd_c   = rd_ptr + AW'(pop_c);
  assign next_occ_c  = occ + CW'(push_c) - CW'(pop_c);

  // Storage array needs no reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_instr[wr_ptr] <= word_c;
      mem_addr[wr_ptr]  <= next_addr;
    end
  end

  // Pointers, bookkeeping, and a registered copy of the head entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      next_addr <= BASE_ADDR;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_addr  <= 64'd0;
      range_err <= 1'b0;
      count     <= 16'd0;
    end else if (start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      next_addr <= BASE_ADDR;
      out_valid <= 1'b0;
      range_err <= 1'b0;
      count     <= 16'd0;
    end else begin
      rd_ptr    <= next_rd_c;
      occ       <= next_occ_c;
      out_valid <= (next_occ_c != '0);
      if (accept_c && !push_c) begin
        range_err <= 1'b1;
      end
      if (push_c) begin
        wr_ptr    <= wr_ptr + AW'(1);
        next_addr <= next_addr + 64'd4;
        if (count != 16'hFFFF) begin
          count <= count + 16'd1;
        end
      end
      // When the FIFO drains, the head registers keep the last popped word.
      if (next_occ_c != '0) begin
        if (push_c && (next_rd_c == wr_ptr)) begin
          out_instr <= word_c;
          out_addr  <= next_addr;
        end else begin
          out_instr <= mem_instr[next_rd_c];
          out_addr  <= mem_addr[next_rd_c];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_word_packer.sv
// Randomized bench for instr_word_packer against a queue-based reference model.
module tb_instr_word_packer;

  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] BASE  = 64'd0;

  logic        clk, reset, start, in_valid, in_ready, out_valid, out_ready, range_err;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [63:0] in_imm, out_addr;
  logic [31:0] out_instr;
  logic [15:0] count;

  instr_word_packer #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .range_err(range_err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_addr;
  logic        m_err;
  int          m_cnt;
  logic        last_acc;
  logic        cmp_en;
  int          tests, fails;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding built from shifted, masked fields by instruction format.
  function automatic logic [31:0] pack(input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [6:0] f7, input logic [63:0] imm);
    logic [63:0] w;
    w = 64'(op) | (64'(rd) << 7) | (64'(f3) << 12) | (64'(rs1) << 15) | (64'(rs2) << 20);
    if ((op >> 4) == 7'd3)
      w = w | (64'(f7) << 25);
    else if ((op >> 5) == 7'd0)
      w = (w & 64'h000F_FFFF) | ((imm & 64'hFFF) << 20);
    else if ((op >> 5) == 7'd1)
      w = (w & 64'h01FF_F07F) | (((imm >> 5) & 64'h7F) << 25) | ((imm & 64'h1F) << 7);
    else
      w = (w & 64'h01FF_F07F) | (((imm >> 11) & 64'h1) << 31) | (((imm >> 4) & 64'h3F) << 25)
        | ((imm & 64'hF) << 8) | (((imm >> 10) & 64'h1) << 7);
    return 32'(w);
  endfunction

  function automatic logic needs_imm(input logic [6:0] op);
    return (op >> 4) != 7'd3;
  endfunction

  function automatic logic in_range(input logic [63:0] imm);
    logic signed [63:0] s;
    s = imm;
    return (s >= -64'sd2048) && (s <= 64'sd2047);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_addr = BASE;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  // One clock: predict handshakes from current inputs, then advance the model.
  task automatic step();
    logic acc, pop;
    acc = in_valid && reset && (mq.size() < DEPTH) && !start;
    pop = (mq.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    last_acc = acc;
    if (start) begin
      model_clear();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        if (!needs_imm(in_opcode) || in_range(in_imm)) begin
          mq.push_back('{instr: pack(in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm),
                         addr: m_addr});
          m_addr = m_addr + 64'd4;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic set_bundle(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7, input logic [63:0] imm);
    in_opcode = op; in_rd = rd; in_funct3 = f3; in_rs1 = rs1;
    in_rs2 = rs2; in_funct7 = f7; in_imm = imm;
  endtask

  // Hold the bundle until accepted, with a bounded wait.
  task automatic offer();
    logic done;
    done = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      if (last_acc) done = 1'b1;
    end
    in_valid = 1'b0;
    check("offer_accepted", 64'(done), 64'd1);
  endtask

  task automatic rand_bundle();
    logic [63:0] imm;
    case ($urandom_range(0, 7))
      0: imm = 64'd2047;
      1: imm = -64'sd2048;
      2: imm = 64'd2048;
      3: imm = -64'sd2049;
      4: imm = {$urandom, $urandom};
      default: imm = 64'($urandom_range(0, 4095)) - 64'd2048;
    endcase
    set_bundle(7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
               7'($urandom), imm);
  endtask

  // Continuous comparison of every observable output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("out_instr", 64'(out_instr), 64'(mq[0].instr));
        check("out_addr", out_addr, mq[0].addr);
      end
      check("in_ready", 64'(in_ready), 64'(reset && (mq.size() < DEPTH) && !start));
      check("range_err", 64'(range_err), 64'(m_err));
      check("count", 64'(count), 64'(m_cnt));
    end
  end

  initial begin
    tests = 0; fails = 0; cmp_en = 1'b0; last_acc = 1'b0;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_bundle(7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 64'd0);
    model_clear();

    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_addr", out_addr, 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_range_err", 64'(range_err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1; cmp_en = 1'b1;

    // Directed format cases with hand-computed encodings.
    out_ready = 1'b1;
    set_bundle(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 64'd5);
    offer();
    check("itype_instr", 64'(out_instr), 64'h0050_0093);
    check("itype_addr", out_addr, 64'h0);
    check("itype_count", 64'(count), 64'd1);
    set_bundle(7'b0100011, 5'd0, 3'b010, 5'd1, 5'd2, 7'd0, 64'd8);
    offer();
    check("stype_instr", 64'(out_instr), 64'h0020_A423);
    check("stype_addr", out_addr, 64'h4);
    set_bundle(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, -64'sd4);
    offer();
    check("sbtype_instr", 64'(out_instr), 64'hFE20_8CE3);
    check("sbtype_addr", out_addr, 64'h8);
    set_bundle(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 64'd2048);
    offer();
    check("range_err_set", 64'(range_err), 64'd1);
    check("range_count", 64'(count), 64'd3);
    set_bundle(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, -64'sd2048);
    offer();
    check("neg_imm_instr", 64'(out_instr), 64'h8000_0093);
    check("neg_imm_addr", out_addr, 64'hC);
    step();

    // Backpressure: four accepts fill the FIFO, the rest wait for drain.
    start = 1'b1; step(); start = 1'b0;
    check("start_err_clr", 64'(range_err), 64'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_bundle(7'b0110011, 5'(i), 3'd0, 5'd3, 5'd4, 7'd0, 64'd0);
      offer();
    end
    set_bundle(7'b0010011, 5'd7, 3'd0, 5'd1, 5'd0, 7'd0, 64'd100);
    in_valid = 1'b1;
    step(); step();
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head_addr", out_addr, 64'd0);
    out_ready = 1'b1;
    offer();
    set_bundle(7'b0010011, 5'd8, 3'd0, 5'd1, 5'd0, 7'd0, 64'd200);
    offer();
    for (int i = 0; i < 8; i++) step();
    check("bp_count", 64'(count), 64'd6);
    check("bp_last_addr", out_addr, 64'd20);

    // start with three words buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_bundle(); in_imm = 64'd1; offer();
    end
    start = 1'b1; in_valid = 1'b1; step(); start = 1'b0; in_valid = 1'b0;
    check("start_out_valid", 64'(out_valid), 64'd0);
    check("start_count", 64'(count), 64'd0);
    set_bundle(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 64'd9);
    offer();
    check("start_base_addr", out_addr, BASE);

    // Randomized traffic with occasional restarts.
    for (int i = 0; i < 600; i++) begin
      rand_bundle();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      start     = ($urandom_range(0, 39) == 0);
      step();
    end
    start = 1'b0; in_valid = 1'b0;

    // Async reset in the middle of a burst.
    out_ready = 1'b0;
    rand_bundle(); in_imm = 64'd3; offer();
    rand_bundle(); in_imm = 64'd4; offer();
    #2;
    cmp_en = 1'b0;
    reset = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_out_instr", 64'(out_instr), 64'd0);
    check("async_out_addr", out_addr, 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_range_err", 64'(range_err), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd0);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b1; cmp_en = 1'b1;
    out_ready = 1'b1;
    set_bundle(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 64'd5);
    offer();
    check("post_reset_addr", out_addr, BASE);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_word_packer.md
Name: instr_word_packer

Overview:
- Encoder counterpart to the immediate generator: takes decoded instruction fields plus a 64-bit signed immediate and packs them into a 32-bit RV64 instruction word.
- Immediate placement uses the same format split the decode side uses: opcode[6:5]=00 is I-type, 01 is S-type, 1x is SB-type; opcode[6:4]=011 is R-type.
- Packed words are buffered in a small FIFO and tagged with a sequential byte address. The output stream feeds the instruction-memory loader and the self-check harness.

Parameters:
- BASE_ADDR, 64'd0, address assigned to the first word after reset or start.
- FIFO_DEPTH, 4, output buffer entries; power of 2, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  synchronous pulse: flush the FIFO, reload the address, clear error and count.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  packer can accept a bundle.
- in_opcode  in  7  opcode field.
- in_rd  in  5  destination register.
- in_funct3  in  3  funct3 field.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct7  in  7  funct7 field (R-type only).
- in_imm  in  64  signed immediate; for SB-type this is the halfword offset (byte offset >> 1).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_instr  out  32  packed word at the FIFO head.
- out_addr  out  64  byte address of the head word.
- range_err  out  1  sticky: a bundle was rejected for immediate range.
- count  out  16  number of words enqueued since reset or start; saturates at 16'hFFFF.

Behaviour:
- Reset (async, reset=0): FIFO empty, out_valid=0, out_instr=0, out_addr=0, next_addr=BASE_ADDR, range_err=0, count=0, in_ready=0 while reset is asserted.
- Accept condition: in_valid && in_ready at a clock edge.
- in_ready = !fifo_full && !start. No same-cycle pop bypass, so a full FIFO holds in_ready low even when out_ready=1.
- Packing (combinational, before the FIFO):
  - opcode, rd, funct3, rs1 and rs2 always go to [6:0], [11:7], [14:12], [19:15] and [24:20].
  - The immediate fields below overwrite the register fields they overlap.
  - R-type (opcode[6:4]=011): [31:25]=funct7; no immediate and no range check.
  - I-type: [31:20]=imm[11:0]; rs2 ignored.
  - S-type (opcode[6:5]=01, not R): [31:25]=imm[11:5], [11:7]=imm[4:0]; rd ignored.
  - SB-type: [31]=imm[11], [30:25]=imm[9:4], [11:8]=imm[3:0], [7]=imm[10]; rd ignored.
- Range rule (I, S, SB): in_imm[63:11] must be all zeros or all ones, i.e. -2048..2047.
  - On violation the bundle is consumed (handshake completes) but not enqueued.
  - range_err is set to 1; next_addr and count are unchanged.
- Enqueue: the word and next_addr are written to the FIFO; next_addr += 4; count += 1.
- Latency: a bundle accepted at edge N appears at the FIFO head with out_valid=1 after edge N, provided the FIFO was empty.
- Dequeue: out_valid && out_ready pops the head at the edge. Simultaneous push and pop when not full keeps occupancy unchanged.
- FIFO order is strict in-order. out_instr and out_addr hold their values while out_valid=1 && out_ready=0.
- Empty FIFO: out_valid=0; out_instr and out_addr hold their last popped values.
- Address wrap: next_addr wraps modulo 2^64 with no flag.
- start (also valid mid-stream):
  - Takes effect at the next edge: FIFO cleared, out_valid=0, next_addr=BASE_ADDR, range_err=0, count=0.
  - Any in_valid in the start cycle is not accepted.
- Mid-operation reset: returns immediately to the reset state; in-flight words are lost.

Test Plan:
- I-type: opcode=0010011, rd=1, rs1=0, funct3=0, imm=5, out_ready=1 -> out_instr=0x00500093, out_addr=0x0, count=1, one cycle after accept.
- S-type: opcode=0100011, rs1=1, rs2=2, funct3=010, imm=8 -> 0x0020A423 at out_addr=0x4.
- SB-type: opcode=1100011, rs1=1, rs2=2, funct3=000, imm=-4 (halfword offset, byte offset -8) -> 0xFE208CE3 at out_addr=0x8.
- Range: I-type imm=2048 -> handshake completes, no output, range_err=1, next word still at the next sequential address; then imm=-2048 -> accepted with [31:20]=0x800.
- Backpressure: out_ready=0, offer 6 bundles -> in_ready drops after 4 accepts. Raise out_ready -> words pop in order at addrs 0, 4, 8, 12, then the remaining 2 accept at 16 and 20.
- start pulse with 3 words buffered -> out_valid=0 next cycle, count=0, range_err=0; next accepted word gets out_addr=BASE_ADDR.
- Async reset asserted mid-burst, then released -> all outputs at reset values before the next clock edge.
